vend_ctrl_param: RTL
====================

VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  PRICE, 20, item price in credit units
  W, 6, credit/change width in bits
  P_VAL, 1, value of coin p
  N_VAL, 5, value of coin n
  D_VAL, 10, value of coin d
  Q_VAL, 25, value of coin q
  TIMEOUT, 30, idle cycles in COLLECT before automatic refund
REQ-002 Legal parameters SHALL satisfy PRICE>=1, TIMEOUT>=1, and 2^W-1 >= PRICE-1+max coin value; other settings are unsupported.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk, in, 1, single system clock, rising edge
  rst, in, 1, reset, asynchronous, active-high
  p, in, 1, coin p inserted (one-cycle pulse)
  n, in, 1, coin n inserted
  d, in, 1, coin d inserted
  q, in, 1, coin q inserted
  cancel, in, 1, refund request
  vend_ack, in, 1, dispenser has taken the item
  credit, out, W, accumulated credit
  vend, out, 1, dispense request, held until acknowledged
  change, out, W, amount returned, valid with change_valid
  change_valid, out, 1, one-cycle change/refund strobe
  coin_rej, out, 1, one-cycle strobe: coin ignored
REQ-004 Clock is clk only; reset is rst, asynchronous, active-high; the block has no other clock or reset.

Function
REQ-005 The FSM SHALL have states IDLE, COLLECT, VEND and CHANGE, all registered on posedge clk.
REQ-006 Coin priority on simultaneous inputs SHALL be p > n > d > q: only the highest-priority asserted coin is accepted, and coin_rej pulses for one cycle when more than one is asserted.
REQ-007 In IDLE/COLLECT, an accepted coin SHALL add its value to credit, visible on the cycle after sampling (1-cycle latency).
REQ-008 In IDLE, an accepted coin SHALL move the FSM to COLLECT, or to VEND if the new credit is >= PRICE.
REQ-009 In COLLECT, when the updated credit is >= PRICE, the FSM SHALL enter VEND in the same cycle credit updates.
REQ-010 vend SHALL be 1 exactly while in VEND; credit holds its value in VEND.
REQ-011 In VEND with vend_ack=1, the next state SHALL be CHANGE with change=credit-PRICE.
REQ-012 CHANGE SHALL last one cycle with change_valid=1 (including change=0), then the FSM enters IDLE with credit=0 and change=0.
REQ-013 Coins asserted in VEND or CHANGE SHALL be ignored, with coin_rej=1 for that cycle and credit unchanged.
REQ-014 cancel in COLLECT SHALL move the FSM to CHANGE with change=credit (full refund); cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-015 If cancel and a coin arrive in the same COLLECT cycle, cancel SHALL win; the coin is not credited and coin_rej=1.
REQ-016 An idle counter SHALL run in COLLECT and clear on every accepted coin.
REQ-017 When the idle counter reaches TIMEOUT consecutive coin-free cycles, the FSM SHALL enter CHANGE with change=credit.
REQ-018 The idle counter SHALL hold at 0 outside COLLECT.
REQ-019 vend_ack outside VEND SHALL be ignored.
REQ-020 Credit arithmetic SHALL be unsigned W-bit; under REQ-002 it never wraps.

Reset
REQ-021 rst=1 SHALL immediately, without a clock edge, force state=IDLE, credit=0, vend=0, change=0, change_valid=0, coin_rej=0 and idle counter=0.
REQ-022 Reset in any state, including VEND or CHANGE, SHALL discard credit and pending change; no change_valid is issued.
REQ-023 Inputs SHALL be ignored while rst=1; normal operation resumes on the first posedge after deassertion.

Verification
REQ-024 d, d, then vend_ack -> credit 10 then 20 with vend=1 in the same cycle; next cycle change_valid=1 with change=0; then credit=0.
REQ-025 n, n, n, q -> credit 15 then 40 with vend=1; vend_ack -> change=20 with change_valid=1.
REQ-026 p, n and d asserted together from IDLE -> credit=1 and coin_rej=1.
REQ-027 n, p, then 30 coin-free cycles -> change=6 with change_valid=1 on timeout, then credit=0 in IDLE; cancel at credit 12 -> change=12.
REQ-028 q during VEND -> coin_rej=1 and credit unchanged.
REQ-029 rst pulsed mid-VEND between clock edges -> vend=0 and credit=0 immediately, and no change_valid follows.

Source files
------------

// File: rtl/vend_ctrl_param.sv
// Vending machine controller: sums coins into a credit register, requests a
// vend once the price is reached, then pays out change (or a full refund on
// cancel or timeout) in a single-cycle strobe. All outputs are registered.
module vend_ctrl_param #(
    parameter int PRICE   = 20,
    parameter int W       = 6,
    parameter int P_VAL   = 1,
    parameter int N_VAL   = 5,
    parameter int D_VAL   = 10,
    parameter int Q_VAL   = 25,
    parameter int TIMEOUT = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         p,
    input  logic         n,
    input  logic         d,
    input  logic         q,
    input  logic         cancel,
    input  logic         vend_ack,
    output logic [W-1:0] credit,
    output logic         vend,
    output logic [W-1:0] change,
    output logic         change_valid,
    output logic         coin_rej
);

    // Wide enough to hold TIMEOUT-1, the last count before the refund fires.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [W-1:0]  PRICE_W = W'(PRICE);
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    state_t        state;
    logic [CW-1:0] idle_cnt;

    logic          any_coin;
    logic          multi_coin;
    logic [W-1:0]  coin_val;
    logic [W-1:0]  credit_sum;
    logic          reach_price;

    // Priority decode p > n > d > q and the credit after accepting the coin.
    always_comb begin
        coin_val = '0;
        if (p)
            coin_val = W'(P_VAL);
        else if (n)
            coin_val = W'(N_VAL);
        else if (d)
            coin_val = W'(D_VAL);
        else if (q)
            coin_val = W'(Q_VAL);
        any_coin    = p | n | d | q;
        multi_coin  = (p & (n | d | q)) | (n & (d | q)) | (d & q);
        credit_sum  = credit + coin_val;
        reach_price = (credit_sum >= PRICE_W);
    end

    // Controller FSM with all outputs and the idle counter registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            vend         <= 1'b0;
            change       <= '0;
            change_valid <= 1'b0;
            coin_rej     <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            change_valid <= 1'b0;
            coin_rej     <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (any_coin) begin
                        credit   <= credit_sum;
                        coin_rej <= multi_coin;
                        if (reach_price) begin
                            state <= VEND;
                            vend  <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        // Refund wins over a coin arriving in the same cycle.
                        state        <= CHANGE;
                        change       <= credit;
                        change_valid <= 1'b1;
                        coin_rej     <= any_coin;
                        idle_cnt     <= '0;
                    end else if (any_coin) begin
                        credit   <= credit_sum;
                        coin_rej <= multi_coin;
                        idle_cnt <= '0;
                        if (reach_price) begin
                            state <= VEND;
                            vend  <= 1'b1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state        <= CHANGE;
                        change       <= credit;
                        change_valid <= 1'b1;
                        idle_cnt     <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                VEND: begin
                    idle_cnt <= '0;
                    coin_rej <= any_coin;
                    if (vend_ack) begin
                        state        <= CHANGE;
                        vend         <= 1'b0;
                        change       <= credit - PRICE_W;
                        change_valid <= 1'b1;
                    end
                end
                CHANGE: begin
                    // Payout lasts exactly one cycle; the transaction closes here.
                    idle_cnt <= '0;
                    coin_rej <= any_coin;
                    state    <= IDLE;
                    credit   <= '0;
                    change   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
